// File: rtl/note_scroller_pkg.sv
// rtl/note_scroller_pkg.sv - shared state encodings and constants for the note scroller
// Purpose: FSM state type, default geometry and the blank-row value used by
//   note_scroller and note_row_shifter.
// Ports: none (package).
package note_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_ROWS      = 8;
  localparam int DEF_NUM_BEATS = 64;

  localparam logic [3:0] BLANK_ROW = 4'h0;

endpackage

// File: rtl/note_row_shifter.sv
// rtl/note_row_shifter.sv - ROWS x 4-bit falling-note shift register
// Purpose: holds the visible note rows; a shift moves every row one step toward
//   the bottom and loads load_row into row 0.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        synchronous clear of all rows (song restart)
//   shift_en     shift one row down and load row 0
//   load_row     4-bit pattern entering at the top
//   rows         row r at [4r+3:4r]; row 0 = top, ROWS-1 = bottom
module note_row_shifter
  import note_scroller_pkg::*;
#(
  parameter int ROWS = DEF_ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [3:0]        load_row,
  output logic [4*ROWS-1:0] rows
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rows <= {ROWS{BLANK_ROW}};
    end else if (shift_en) begin
      // Row r moves to row r+1; the old bottom row falls off the screen.
      rows <= {rows[4*(ROWS-1)-1:0], load_row};
    end
  end

endmodule

// File: rtl/note_scroller.sv
// rtl/note_scroller.sv - beat sequencer, falling-note buffer, key judge and score
// Purpose: holds the current 4-lane pattern for the external adder, pushes it into
//   the falling-note buffer on every beat, judges the bottom row against key
//   presses accumulated since the previous beat and keeps a saturating hit score.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            pulse: begin/restart song (IDLE/DONE only)
//   pause            level: hold while high
//   beat_tick        pulse per beat
//   key_press        debounced lane buttons (level)
//   next_pattern     adder result (current_pattern + 3)
//   current_pattern  to the adder
//   rows             falling-note buffer, row 0 at [3:0]
//   hit, miss        registered 1-cycle judgement pulses
//   score            saturating hit count
//   state            IDLE=0 RUN=1 PAUSE=2 DONE=3
module note_scroller
  import note_scroller_pkg::*;
#(
  parameter int         ROWS      = DEF_ROWS,
  parameter int         NUM_BEATS = DEF_NUM_BEATS,
  parameter logic [3:0] SEED      = 4'h0,
  parameter int         SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               beat_tick,
  input  logic [3:0]         key_press,
  input  logic [3:0]         next_pattern,
  output logic [3:0]         current_pattern,
  output logic [4*ROWS-1:0]  rows,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state
);

  // Beat counter runs through the song and then ROWS blank beats of flush.
  localparam int               CNT_W     = $clog2(NUM_BEATS + ROWS + 1);
  localparam logic [CNT_W-1:0] SONG_END  = CNT_W'(NUM_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS + ROWS - 1);

  state_t             st, st_nxt;
  logic [CNT_W-1:0]   beat_cnt;
  logic [3:0]         acc;
  logic               init, beat, accum;
  logic               emitting;
  logic [3:0]         bottom, judged;

  assign state    = st;
  assign emitting = (beat_cnt < SONG_END);
  assign bottom   = rows[4*ROWS-1 -: 4];
  // A key pressed in the beat cycle itself still counts for this judgement.
  assign judged   = acc | key_press;

  always_comb begin
    st_nxt = st;
    init   = 1'b0;
    beat   = 1'b0;
    accum  = 1'b0;
    case (st)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          st_nxt = ST_RUN;
          init   = 1'b1;
        end
      end
      ST_RUN: begin
        if (pause) begin
          st_nxt = ST_PAUSE;
        end else if (beat_tick) begin
          beat = 1'b1;
          if (beat_cnt == LAST_BEAT) st_nxt = ST_DONE;
        end else begin
          accum = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (!pause) st_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st              <= ST_IDLE;
      current_pattern <= SEED;
      beat_cnt        <= '0;
      acc             <= 4'h0;
      score           <= '0;
      hit             <= 1'b0;
      miss            <= 1'b0;
    end else begin
      st   <= st_nxt;
      hit  <= 1'b0;
      miss <= 1'b0;
      if (init) begin
        current_pattern <= SEED;
        beat_cnt        <= '0;
        acc             <= 4'h0;
        score           <= '0;
      end else if (beat) begin
        if (bottom != BLANK_ROW) begin
          if (judged == bottom) begin
            hit <= 1'b1;
            if (score != {SCORE_W{1'b1}}) score <= score + SCORE_W'(1);
          end else begin
            miss <= 1'b1;
          end
        end
        // After the song only blanks enter, so the pattern stops advancing.
        if (emitting) current_pattern <= next_pattern;
        beat_cnt <= beat_cnt + CNT_W'(1);
        acc      <= 4'h0;
      end else if (accum) begin
        acc <= acc | key_press;
      end
    end
  end

  note_row_shifter #(.ROWS(ROWS)) u_rows (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (init),
    .shift_en (beat),
    .load_row (emitting ? current_pattern : BLANK_ROW),
    .rows     (rows)
  );

endmodule

// File: tb/tb_note_scroller.sv
// tb/tb_note_scroller.sv - scoreboard bench for note_scroller
module tb_note_scroller;

  localparam int A_ROWS = 8;
  localparam int A_NB   = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // Instance A: long song, used for shift, judge, pause, saturation and reset.
  logic        a_start = 0, a_pause = 0, a_beat = 0;
  logic [3:0]  a_key = 0, a_pat;
  logic [4*A_ROWS-1:0] a_rows;
  logic        a_hit, a_miss;
  logic [7:0]  a_score;
  logic [1:0]  a_state;

  note_scroller #(.ROWS(A_ROWS), .NUM_BEATS(A_NB), .SEED(4'h0), .SCORE_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .pause(a_pause), .beat_tick(a_beat),
    .key_press(a_key), .next_pattern(a_pat + 4'd3), .current_pattern(a_pat),
    .rows(a_rows), .hit(a_hit), .miss(a_miss), .score(a_score), .state(a_state)
  );

  // Instance B: NUM_BEATS=4, ROWS=2 for the flush/DONE/restart path.
  logic        b_start = 0, b_beat = 0;
  logic [3:0]  b_key = 0, b_pat;
  logic [7:0]  b_rows;
  logic        b_hit, b_miss;
  logic [7:0]  b_score;
  logic [1:0]  b_state;

  note_scroller #(.ROWS(2), .NUM_BEATS(4), .SEED(4'h0), .SCORE_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .pause(1'b0), .beat_tick(b_beat),
    .key_press(b_key), .next_pattern(b_pat + 4'd3), .current_pattern(b_pat),
    .rows(b_rows), .hit(b_hit), .miss(b_miss), .score(b_score), .state(b_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {hit, miss, score} for every judgement that should pulse.
  logic [9:0] exp_q[$];
  int         a_beats = 0;
  int         score_model = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pattern emitted on beat j of instance A (SEED 0, adder +3 mod 16).
  function automatic logic [3:0] pat_at(input int j);
    if (j < 0 || j >= A_NB) return 4'h0;
    return 4'((3 * j) % 16);
  endfunction

  function automatic logic [3:0] bottom_at(input int k);
    return pat_at(k - A_ROWS);
  endfunction

  function automatic logic [4*A_ROWS-1:0] rows_at(input int k);
    logic [4*A_ROWS-1:0] v;
    v = '0;
    for (int r = 0; r < A_ROWS; r++) v[4*r +: 4] = pat_at(k - 1 - r);
    return v;
  endfunction

  // One beat on A: keys held for one accumulation cycle and the beat cycle.
  task automatic a_do_beat(input logic [3:0] keys);
    logic [3:0] b;
    a_key = keys;
    tick();
    b = bottom_at(a_beats);
    if (b != 4'h0) begin
      if (keys == b) begin
        if (score_model < 255) score_model++;
        exp_q.push_back({1'b1, 1'b0, 8'(score_model)});
      end else begin
        exp_q.push_back({1'b0, 1'b1, 8'(score_model)});
      end
    end
    a_beat = 1'b1;
    tick();
    a_beat = 1'b0;
    a_key  = 4'h0;
    a_beats++;
  endtask

  // Monitor: every judgement pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (a_hit || a_miss) begin
      logic [9:0] e;
      chk("hit_miss_exclusive", {63'd0, a_hit & a_miss}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_judgement", {54'd0, a_hit, a_miss, a_score}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("judgement", {54'd0, a_hit, a_miss, a_score}, {54'd0, e});
      end
    end
  end

  logic [3:0] b_tbl [6];

  initial begin
    b_tbl = '{4'h0, 4'h0, 4'h0, 4'h3, 4'h0, 4'h0};

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_state", a_state, 0);
    chk("rst_pattern", a_pat, 0);
    chk("rst_rows", a_rows, 0);
    chk("rst_score", a_score, 0);
    chk("rst_hitmiss", {a_hit, a_miss}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", a_state, 0);

    // 1. start and three beats
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("start_run", a_state, 1);
    for (int i = 0; i < 3; i++) a_do_beat(4'h0);
    chk("t1_pattern", a_pat, 4'h9);
    chk("t1_row0", a_rows[3:0], 4'h6);
    chk("t1_row1", a_rows[7:4], 4'h3);
    chk("t1_row2", a_rows[11:8], 4'h0);

    // 2/3. Beat 15 has pattern 5 at the bottom: press 5 -> hit; period-16 wrap.
    while (a_beats < 15) a_do_beat(4'h0);
    a_do_beat(4'h5);
    chk("t2_wrap_pattern", a_pat, 4'h0);
    chk("t3_hit_score", a_score, 1);
    // Beat 31 has pattern 5 again: press 4 -> miss, score unchanged.
    while (a_beats < 31) a_do_beat(4'h0);
    a_do_beat(4'h4);
    chk("t3_miss_score", a_score, 1);
    chk("t3_rows", a_rows, rows_at(32));

    // 4. Pause for 10 cycles with beats and keys -> frozen
    a_pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_beat = (i == 2 || i == 5 || i == 8);
      a_key  = 4'hF;
      tick();
    end
    a_beat = 1'b0; a_key = 4'h0;
    chk("t4_pause_state", a_state, 2);
    chk("t4_pause_rows", a_rows, rows_at(32));
    chk("t4_pause_pattern", a_pat, pat_at(32));
    chk("t4_pause_score", a_score, 1);
    a_pause = 1'b0;
    tick();
    chk("t4_resume_state", a_state, 1);
    a_do_beat(bottom_at(a_beats));
    chk("t4_after_rows", a_rows, rows_at(33));
    chk("t4_after_pattern", a_pat, pat_at(33));
    chk("t4_after_score", a_score, 2);

    // Score saturation
    while (score_model < 255 && a_beats < 390) a_do_beat(bottom_at(a_beats));
    chk("sat_reach", a_score, 8'hFF);
    a_do_beat(bottom_at(a_beats));
    a_do_beat(bottom_at(a_beats));
    chk("sat_hold", a_score, 8'hFF);

    // 6. Reset mid-song
    chk("t6_rows_nonzero", {63'd0, a_rows != '0}, 64'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_state", a_state, 0);
    chk("t6_pattern", a_pat, 0);
    chk("t6_rows", a_rows, 0);
    chk("t6_score", a_score, 0);
    chk("t6_hitmiss", {a_hit, a_miss}, 0);
    rst_n = 1'b1;
    tick();

    // 5. Short song on B: 4 beats + 2 flush beats -> DONE, rows blank
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b_key = b_tbl[k];
      tick();
      b_beat = 1'b1;
      tick();
      b_beat = 1'b0;
      b_key  = 4'h0;
      if (k == 4) chk("t5_run_before_last", b_state, 1);
    end
    chk("t5_done", b_state, 3);
    chk("t5_rows", b_rows, 0);
    chk("t5_score", b_score, 1);
    chk("t5_pattern", b_pat, 4'hC);
    tick(); tick();
    chk("t5_done_hold", b_state, 3);
    b_start = 1'b1; tick(); b_start = 1'b0;
    chk("t5_restart_state", b_state, 1);
    chk("t5_restart_score", b_score, 0);
    chk("t5_restart_pattern", b_pat, 0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
